// File: rtl/core_pkg.sv
// Shared widths, opcodes, memory-enable codes and instruction field layout for core.
package core_pkg;
  localparam int REG_SIZE_DEF   = 8;
  localparam int ADDR_SIZE_DEF  = 8;
  localparam int INSN_SIZE_DEF  = 16;
  localparam int INSN_COUNT_DEF = 16;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS0_LSB = 4;
  localparam int RS1_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_MUL  = 4'h3;
  localparam opcode_t OP_AND  = 4'h4;
  localparam opcode_t OP_OR   = 4'h5;
  localparam opcode_t OP_XOR  = 4'h6;
  localparam opcode_t OP_SET  = 4'h7;
  localparam opcode_t OP_LD   = 4'h8;
  localparam opcode_t OP_ST   = 4'h9;
  localparam opcode_t OP_BNZ  = 4'hA;
  localparam opcode_t OP_STOP = 4'hF;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10
  } mem_en_e;

  typedef struct packed {
    opcode_t    op;
    logic [3:0] rd;
    logic [3:0] rs0;
    logic [3:0] rs1;
    logic [7:0] imm;
  } insn_t;

  function automatic insn_t decode(input logic [15:0] w);
    insn_t d;
    d.op  = w[OP_LSB  +: 4];
    d.rd  = w[RD_LSB  +: 4];
    d.rs0 = w[RS0_LSB +: 4];
    d.rs1 = w[RS1_LSB +: 4];
    d.imm = w[IMM_LSB +: 8];
    return d;
  endfunction
endpackage

// File: rtl/core_if.sv
// Shared data-memory port of core: one outstanding request, completed by ready_M.
interface core_if #(
  parameter int REG_SIZE  = 8,
  parameter int ADDR_SIZE = 8
);
  logic [1:0]           enable_M;
  logic [ADDR_SIZE-1:0] addr_M;
  logic [REG_SIZE-1:0]  wr_data_M;
  logic [REG_SIZE-1:0]  rd_data_M;
  logic                 ready_M;

  modport master (output enable_M, addr_M, wr_data_M, input  rd_data_M, ready_M);
  modport slave  (input  enable_M, addr_M, wr_data_M, output rd_data_M, ready_M);
endinterface

// File: rtl/core_alu.sv
// Combinational ALU for core. MUL exists only when CORE_MUL_EN is defined;
// otherwise opcode 3 reports no write-back and no multiplier is built.
module core_alu
  import core_pkg::*;
#(
  parameter int W = REG_SIZE_DEF
) (
  input  opcode_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         we
);
  always_comb begin
    res = '0;
    we  = 1'b1;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
`ifdef CORE_MUL_EN
      OP_MUL: res = a * b;
`endif
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: we = 1'b0;
    endcase
  end
endmodule

// File: rtl/core.sv
// Non-pipelined compute core: latches an instruction block on Start and runs it
// against a 16-entry register file. Optional MUL via CORE_MUL_EN (see core_alu).
module core
  import core_pkg::*;
#(
  parameter int REG_SIZE   = REG_SIZE_DEF,
  parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int INSN_SIZE  = INSN_SIZE_DEF,
  parameter int INSN_COUNT = INSN_COUNT_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_R0_flag,
  input  logic [REG_SIZE-1:0]             init_R0_data,
  input  logic [INSN_SIZE*INSN_COUNT-1:0] insn_data,
  input  logic                            Start,
  output logic                            Ready,
  core_if.master                          mem
);
  localparam int PCW = $clog2(INSN_COUNT);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                                state_q, state_d;
  logic [PCW-1:0]                        pc_q, pc_d;
  logic [INSN_COUNT-1:0][INSN_SIZE-1:0]  buf_q, buf_d;
  logic [15:0][REG_SIZE-1:0]             regs_q, regs_d;

  insn_t               insn;
  logic [REG_SIZE-1:0] a_val, b_val, alu_res;
  logic                alu_we, is_ld, is_st, advance, take_br;

  assign insn  = decode(buf_q[pc_q]);
  assign a_val = regs_q[insn.rs0];
  assign b_val = regs_q[insn.rs1];
  assign is_ld = (state_q == S_RUN) && (insn.op == OP_LD);
  assign is_st = (state_q == S_RUN) && (insn.op == OP_ST);
  assign Ready = (state_q == S_IDLE);

  core_alu #(.W(REG_SIZE)) u_alu (
    .op (insn.op),
    .a  (a_val),
    .b  (b_val),
    .res(alu_res),
    .we (alu_we)
  );

  // Store data comes from the [7:4] register field; the address from rd.
  assign mem.enable_M  = is_ld ? MEM_RD : (is_st ? MEM_WR : MEM_IDLE);
  assign mem.addr_M    = is_ld ? ADDR_SIZE'(a_val)
                       : (is_st ? ADDR_SIZE'(regs_q[insn.rd]) : '0);
  assign mem.wr_data_M = is_st ? a_val : '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    regs_d  = regs_q;
    advance = 1'b0;
    take_br = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_R0_flag) regs_d[0] = init_R0_data;
        if (Start) begin
          buf_d   = insn_data;
          pc_d    = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        advance = !((is_ld || is_st) && !mem.ready_M);
        take_br = (insn.op == OP_BNZ) && (regs_q[insn.rd] != '0);
        if (alu_we) regs_d[insn.rd] = alu_res;
        if (insn.op == OP_SET) regs_d[insn.rd] = REG_SIZE'(insn.imm);
        if (is_ld && mem.ready_M) regs_d[insn.rd] = mem.rd_data_M;
        if (advance) begin
          pc_d = take_br ? insn.imm[PCW-1:0] : pc_q + 1'b1;
          // Falling off the end of the block halts just like STOP.
          if ((insn.op == OP_STOP) || (!take_br && pc_q == PCW'(INSN_COUNT-1))) begin
            state_d = S_IDLE;
            pc_d    = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      buf_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_core.sv
// Directed, table-driven bench for core: block programs with hand-computed
// memory traffic and busy-cycle counts, plus stall/reset/busy-Start sequences.
module tb_core;
  logic         clk = 1'b0;
  logic         reset;
  logic         init_R0_flag;
  logic [7:0]   init_R0_data;
  logic [255:0] insn_data;
  logic         Start;
  logic         Ready;

  core_if #(.REG_SIZE(8), .ADDR_SIZE(8)) mem_if ();

  core dut (
    .clk         (clk),
    .reset       (reset),
    .init_R0_flag(init_R0_flag),
    .init_R0_data(init_R0_data),
    .insn_data   (insn_data),
    .Start       (Start),
    .Ready       (Ready),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        name;
    logic [255:0] prog;
    logic         init;
    logic [7:0]   init_val;
    logic [7:0]   rdv;
    int           stall;
    int           busy;
    int           nwr;
    logic [7:0]   waddr;
    logic [7:0]   wdata;
    int           nrd;
    logic [7:0]   raddr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] blk(input logic [15:0] i0, input logic [15:0] i1 = 16'h0,
                                       input logic [15:0] i2 = 16'h0, input logic [15:0] i3 = 16'h0,
                                       input logic [15:0] i4 = 16'h0, input logic [15:0] i5 = 16'h0,
                                       input logic [15:0] i6 = 16'h0);
    logic [255:0] b;
    b = '0;
    b[15:0] = i0; b[31:16] = i1; b[47:32] = i2; b[63:48] = i3;
    b[79:64] = i4; b[95:80] = i5; b[111:96] = i6;
    return b;
  endfunction

  // Launches one block and services memory until Ready; stall applies to the first access.
  task automatic run_block(input logic [255:0] prog, input logic init, input logic [7:0] init_val,
                           input logic [7:0] rdv, input int stall,
                           output int busy, output int nwr, output logic [7:0] waddr,
                           output logic [7:0] wdata, output int nrd, output logic [7:0] raddr,
                           output int serr);
    int         stall_left;
    logic       in_acc;
    logic [1:0] en, se;
    logic [7:0] sa, sd;
    busy = 0; nwr = 0; nrd = 0; serr = 0; waddr = '0; wdata = '0; raddr = '0;
    stall_left = stall; in_acc = 1'b0; se = '0; sa = '0; sd = '0;
    @(negedge clk);
    insn_data = prog; Start = 1'b1; init_R0_flag = init; init_R0_data = init_val;
    mem_if.rd_data_M = rdv;
    @(negedge clk);
    Start = 1'b0; init_R0_flag = 1'b0;
    insn_data = {16{16'h7155}};
    while (!Ready && busy < 200) begin
      busy++;
      en = mem_if.enable_M;
      if (en == 2'b11) serr++;
      if (en != 2'b00) begin
        if (in_acc && (en != se || mem_if.addr_M != sa || mem_if.wr_data_M != sd)) serr++;
        se = en; sa = mem_if.addr_M; sd = mem_if.wr_data_M;
        if (stall_left > 0) begin
          mem_if.ready_M = 1'b0;
          stall_left--;
        end else begin
          mem_if.ready_M = 1'b1;
        end
        in_acc = !mem_if.ready_M;
        if (mem_if.ready_M && en == 2'b10) begin nwr++; waddr = sa; wdata = sd; end
        if (mem_if.ready_M && en == 2'b01) begin nrd++; raddr = sa; end
      end else begin
        mem_if.ready_M = 1'b1;
        in_acc = 1'b0;
      end
      @(negedge clk);
    end
    mem_if.ready_M = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy, nwr, nrd, serr;
    logic [7:0] waddr, wdata, raddr;

    vecs[0]  = '{"reset_regs", blk(16'h7410, 16'h9450, 16'hF000), 0, 8'h00, 8'h00, 0, 3, 1, 8'h10, 8'h00, 0, 8'h00};
    vecs[1]  = '{"store",  blk(16'h7105, 16'h7203, 16'h1312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'h08, 0, 8'h00};
    vecs[2]  = '{"stall3", blk(16'h7105, 16'h7203, 16'h1312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 3, 9, 1, 8'h10, 8'h08, 0, 8'h00};
    vecs[3]  = '{"init_r0", blk(16'h7110, 16'h9100, 16'hF000), 1, 8'h2A, 8'h00, 0, 3, 1, 8'h10, 8'h2A, 0, 8'h00};
    vecs[4]  = '{"sub_wrap", blk(16'h7103, 16'h7205, 16'h2312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'hFE, 0, 8'h00};
    vecs[5]  = '{"and", blk(16'h71F0, 16'h723C, 16'h4312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'h30, 0, 8'h00};
    vecs[6]  = '{"or",  blk(16'h71F0, 16'h720C, 16'h5312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'hFC, 0, 8'h00};
    vecs[7]  = '{"xor", blk(16'h71F0, 16'h72FF, 16'h6312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'h0F, 0, 8'h00};
    vecs[8]  = '{"add_wrap", blk(16'h71F0, 16'h7220, 16'h1312, 16'h7410, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0, 6, 1, 8'h10, 8'h10, 0, 8'h00};
    vecs[9]  = '{"ld_stall2", blk(16'h7120, 16'h8210, 16'h7330, 16'h9320, 16'hF000), 0, 8'h00, 8'h5C, 2, 7, 1, 8'h30, 8'h5C, 1, 8'h20};
    vecs[10] = '{"bnz_loop", blk(16'h7103, 16'h72FF, 16'h1112, 16'hA101, 16'hF000), 0, 8'h00, 8'h00, 0, 11, 0, 8'h00, 8'h00, 0, 8'h00};
    vecs[11] = '{"after_loop", blk(16'h7420, 16'h9410, 16'hF000), 0, 8'h00, 8'h00, 0, 3, 1, 8'h20, 8'h00, 0, 8'h00};
    vecs[12] = '{"all_nop", '0, 0, 8'h00, 8'h00, 0, 16, 0, 8'h00, 8'h00, 0, 8'h00};
    vecs[13] = '{"rsvd_ops", blk(16'hB1FF, 16'hC1FF, 16'hD1FF, 16'hE1FF, 16'h7410, 16'h9410, 16'hF000), 0, 8'h00, 8'h00, 0, 7, 1, 8'h10, 8'h00, 0, 8'h00};

    reset = 1'b1; Start = 1'b0; init_R0_flag = 1'b0; init_R0_data = '0; insn_data = '0;
    mem_if.ready_M = 1'b1; mem_if.rd_data_M = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset/Ready", Ready, 1);
    check("reset/enable_M", mem_if.enable_M, 0);
    check("reset/addr_M", mem_if.addr_M, 0);
    check("reset/wr_data_M", mem_if.wr_data_M, 0);
    repeat (3) @(negedge clk);
    check("hold/Ready", Ready, 1);
    check("hold/enable_M", mem_if.enable_M, 0);

    for (int i = 0; i < 14; i++) begin
      run_block(vecs[i].prog, vecs[i].init, vecs[i].init_val, vecs[i].rdv, vecs[i].stall,
                busy, nwr, waddr, wdata, nrd, raddr, serr);
      check({vecs[i].name, "/busy_cycles"}, busy, vecs[i].busy);
      check({vecs[i].name, "/writes"}, nwr, vecs[i].nwr);
      check({vecs[i].name, "/reads"}, nrd, vecs[i].nrd);
      check({vecs[i].name, "/bus_stable"}, serr, 0);
      check({vecs[i].name, "/idle_enable"}, mem_if.enable_M, 0);
      if (vecs[i].nwr > 0) begin
        check({vecs[i].name, "/wr_addr"}, waddr, vecs[i].waddr);
        check({vecs[i].name, "/wr_data"}, wdata, vecs[i].wdata);
      end
      if (vecs[i].nrd > 0) check({vecs[i].name, "/rd_addr"}, raddr, vecs[i].raddr);
    end

    // Reset while a store is stalled: outputs drop to idle, registers clear.
    @(negedge clk);
    insn_data = blk(16'h7410, 16'h7577, 16'h9450, 16'hF000);
    Start = 1'b1; mem_if.ready_M = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    for (int k = 0; k < 10 && mem_if.enable_M != 2'b10; k++) @(negedge clk);
    check("rst_mid/st_active", mem_if.enable_M, 2);
    check("rst_mid/st_data", mem_if.wr_data_M, 8'h77);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_if.ready_M = 1'b1;
    check("rst_mid/Ready", Ready, 1);
    check("rst_mid/enable_M", mem_if.enable_M, 0);
    check("rst_mid/addr_M", mem_if.addr_M, 0);
    check("rst_mid/wr_data_M", mem_if.wr_data_M, 0);
    run_block(blk(16'h7410, 16'h9450, 16'hF000), 0, 8'h00, 8'h00, 0, busy, nwr, waddr, wdata, nrd, raddr, serr);
    check("rst_mid/regs_cleared", wdata, 8'h00);
    check("rst_mid/post_writes", nwr, 1);

    run_block(blk(16'h7106, 16'h7207, 16'h3312, 16'h7420, 16'h9430, 16'hF000), 0, 8'h00, 8'h00, 0,
              busy, nwr, waddr, wdata, nrd, raddr, serr);
    check("mul/busy_cycles", busy, 6);
    check("mul/wr_addr", waddr, 8'h20);
`ifdef CORE_MUL_EN
    check("mul/wr_data", wdata, 8'h2A);
`else
    check("mul/wr_data", wdata, 8'h00);
`endif

    // Start pulsed while busy must neither restart nor swap the block.
    @(negedge clk);
    insn_data = '0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    busy = 0; nwr = 0;
    while (!Ready && busy < 100) begin
      busy++;
      if (mem_if.enable_M == 2'b10) nwr++;
      Start = (busy == 3);
      if (busy == 3) insn_data = blk(16'h7410, 16'h9400, 16'hF000);
      @(negedge clk);
    end
    Start = 1'b0;
    check("busy_start/busy_cycles", busy, 16);
    check("busy_start/writes", nwr, 0);
    repeat (2) @(negedge clk);
    check("busy_start/stays_idle", Ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
